// File: rtl/nta_pkg.sv
// nta_pkg: shared states, AXI response codes and completion codes for the rv_axil_bridge.
package nta_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE} state_t;
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] EXOKAY  = 2'b01;
  localparam logic [1:0] SLVERR  = 2'b10;
  localparam logic [1:0] DECERR  = 2'b11;
  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_RD   = 2'b01;
  localparam logic [1:0] MD_WR   = 2'b10;
  localparam logic [1:0] MD_TO   = 2'b11;
  function automatic logic resp_err(input logic [1:0] resp);
    return resp == SLVERR || resp == DECERR;
  endfunction
endpackage

// File: rtl/nta_watchdog.sv
// nta_watchdog: counts busy cycles of one transaction and flags expiry on the last allowed cycle.
module nta_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic aclk,
  input  logic reset,
  input  logic busy,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= busy ? cnt + 16'd1 : '0;
  end
  // cnt holds the number of busy cycles already elapsed, so this fires in the TIMEOUT_CYCLES-th one
  assign expired = busy && cnt == 16'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/rv_axil_bridge.sv
// rv_axil_bridge: RISC-V native memory port to AXI4-Lite master, one transaction at a time.
// Optional watchdog timeout enabled by defining NTA_TIMEOUT_EN.
module rv_axil_bridge
  import nta_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                aclk,
  input  logic                reset,
  input  logic                rv_m_valid,
  input  logic                rv_m_rw,
  input  logic [ADDR_W-1:0]   rv_m_addr,
  input  logic [DATA_W-1:0]   rv_m_wrdata,
  input  logic [DATA_W/8-1:0] rv_m_wstrb,
  output logic                rv_m_ready,
  output logic [DATA_W-1:0]   rv_m_rdata,
  output logic                rv_m_err,
  output logic [1:0]          mem_done,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_prot,
  output logic                ar_valid,
  input  logic                ar_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_valid,
  output logic                r_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_prot,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_valid,
  input  logic                w_ready,
  input  logic [1:0]          b_resp,
  input  logic                b_valid,
  output logic                b_ready
);
  state_t state, state_n;
  logic aw_done, w_done, aw_done_n, w_done_n, expired;
  logic ar_valid_n, r_ready_n, aw_valid_n, w_valid_n, b_ready_n, ready_n, err_n;
  logic [ADDR_W-1:0] ar_addr_n, aw_addr_n;
  logic [DATA_W-1:0] w_data_n, rdata_n;
  logic [DATA_W/8-1:0] w_strb_n;
  logic [1:0] md_n;

  assign ar_prot = 3'b000;
  assign aw_prot = 3'b000;

`ifdef NTA_TIMEOUT_EN
  logic busy;
  assign busy = state != IDLE && state != DONE;
  nta_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (.aclk(aclk), .reset(reset), .busy(busy), .expired(expired));
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_n = state;
    aw_done_n = aw_done;
    w_done_n = w_done;
    ar_addr_n = ar_addr;
    aw_addr_n = aw_addr;
    w_data_n = w_data;
    w_strb_n = w_strb;
    ar_valid_n = ar_valid;
    r_ready_n = r_ready;
    aw_valid_n = aw_valid;
    w_valid_n = w_valid;
    b_ready_n = b_ready;
    ready_n = 1'b0;
    md_n = MD_NONE;
    rdata_n = rv_m_rdata;
    err_n = rv_m_err;
    case (state)
      IDLE: if (rv_m_valid) begin
        ar_addr_n = rv_m_addr;
        aw_addr_n = rv_m_addr;
        w_data_n = rv_m_wrdata;
        w_strb_n = rv_m_wstrb;
        aw_done_n = 1'b0;
        w_done_n = 1'b0;
        if (!rv_m_rw) begin
          state_n = RD_ADDR;
          ar_valid_n = 1'b1;
        end else if (|rv_m_wstrb) begin
          state_n = WR;
          aw_valid_n = 1'b1;
          w_valid_n = 1'b1;
        end else begin
          state_n = DONE;
          ready_n = 1'b1;
          md_n = MD_WR;
          err_n = 1'b0;
          rdata_n = '0;
        end
      end
      RD_ADDR: if (ar_ready) begin
        ar_valid_n = 1'b0;
        r_ready_n = 1'b1;
        state_n = RD_DATA;
      end
      RD_DATA: if (r_valid) begin
        r_ready_n = 1'b0;
        rdata_n = r_data;
        err_n = resp_err(r_resp);
        ready_n = 1'b1;
        md_n = MD_RD;
        state_n = DONE;
      end
      WR: begin
        aw_done_n = aw_done | (aw_valid & aw_ready);
        w_done_n = w_done | (w_valid & w_ready);
        aw_valid_n = !aw_done_n;
        w_valid_n = !w_done_n;
        if (aw_done_n && w_done_n) begin
          state_n = WR_RESP;
          b_ready_n = 1'b1;
        end
      end
      WR_RESP: if (b_valid) begin
        b_ready_n = 1'b0;
        err_n = resp_err(b_resp);
        rdata_n = '0;
        ready_n = 1'b1;
        md_n = MD_WR;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    if (expired) begin
      ar_valid_n = 1'b0;
      r_ready_n = 1'b0;
      aw_valid_n = 1'b0;
      w_valid_n = 1'b0;
      b_ready_n = 1'b0;
      ready_n = 1'b1;
      md_n = MD_TO;
      err_n = 1'b1;
      rdata_n = '0;
      state_n = DONE;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      ar_addr <= '0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      ar_valid <= 1'b0;
      r_ready <= 1'b0;
      aw_valid <= 1'b0;
      w_valid <= 1'b0;
      b_ready <= 1'b0;
      rv_m_ready <= 1'b0;
      mem_done <= MD_NONE;
      rv_m_rdata <= '0;
      rv_m_err <= 1'b0;
    end else begin
      state <= state_n;
      aw_done <= aw_done_n;
      w_done <= w_done_n;
      ar_addr <= ar_addr_n;
      aw_addr <= aw_addr_n;
      w_data <= w_data_n;
      w_strb <= w_strb_n;
      ar_valid <= ar_valid_n;
      r_ready <= r_ready_n;
      aw_valid <= aw_valid_n;
      w_valid <= w_valid_n;
      b_ready <= b_ready_n;
      rv_m_ready <= ready_n;
      mem_done <= md_n;
      rv_m_rdata <= rdata_n;
      rv_m_err <= err_n;
    end
  end
endmodule

// File: tb/tb_rv_axil_bridge.sv
// tb_rv_axil_bridge: scoreboard bench with a latency-configurable AXI4-Lite slave model.
module tb_rv_axil_bridge;
  import nta_pkg::*;
  localparam int AW = 32, DW = 32, SW = DW / 8;

  logic aclk = 1'b0, reset = 1'b1;
  logic rv_m_valid = 1'b0, rv_m_rw = 1'b0;
  logic [AW-1:0] rv_m_addr = '0;
  logic [DW-1:0] rv_m_wrdata = '0;
  logic [SW-1:0] rv_m_wstrb = '0;
  logic rv_m_ready, rv_m_err;
  logic [DW-1:0] rv_m_rdata;
  logic [1:0] mem_done;
  logic [AW-1:0] ar_addr, aw_addr;
  logic [2:0] ar_prot, aw_prot;
  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic ar_ready = 1'b0, r_valid = 1'b0, aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] r_data = '0, w_data;
  logic [SW-1:0] w_strb;
  logic [1:0] r_resp = '0, b_resp = '0;

  typedef struct { logic [DW-1:0] rdata; logic err; logic [1:0] md; int cyc; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  bit ar_never = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, aw_seen = 0, w_seen = 0;
  logic [DW-1:0] rd_val = '0;
  logic [1:0] rd_resp = OKAY, wr_resp = OKAY;
  logic [AW-1:0] got_ar_addr = '0, got_aw_addr = '0;
  logic [DW-1:0] got_w_data = '0;
  logic [SW-1:0] got_w_strb = '0;
  logic pv_ar = 0, pv_aw = 0, pv_w = 0;
  logic [AW-1:0] p_ar = '0, p_aw = '0;
  logic [DW+SW-1:0] p_w = '0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  rv_axil_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .reset(reset),
    .rv_m_valid(rv_m_valid), .rv_m_rw(rv_m_rw), .rv_m_addr(rv_m_addr),
    .rv_m_wrdata(rv_m_wrdata), .rv_m_wstrb(rv_m_wstrb),
    .rv_m_ready(rv_m_ready), .rv_m_rdata(rv_m_rdata), .rv_m_err(rv_m_err), .mem_done(mem_done),
    .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  // Slave: a ready/valid it drove last negedge means the handshake completed at the posedge between.
  always @(negedge aclk) begin
    if (reset) begin
      ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    end else begin
      if (aw_valid) aw_seen++;
      if (w_valid) w_seen++;
      if (ar_ready) ar_ready = 0;
      else if (ar_valid && !ar_never) begin
        if (ar_cnt >= ar_lat) begin ar_ready = 1; ar_cnt = 0; got_ar_addr = ar_addr; end
        else ar_cnt++;
      end
      if (r_valid) r_valid = 0;
      else if (r_ready) begin
        if (r_cnt >= r_lat) begin r_valid = 1; r_data = rd_val; r_resp = rd_resp; r_cnt = 0; end
        else r_cnt++;
      end
      if (aw_ready) aw_ready = 0;
      else if (aw_valid) begin
        if (aw_cnt >= aw_lat) begin aw_ready = 1; aw_cnt = 0; got_aw_addr = aw_addr; end
        else aw_cnt++;
      end
      if (w_ready) w_ready = 0;
      else if (w_valid) begin
        if (w_cnt >= w_lat) begin w_ready = 1; w_cnt = 0; got_w_data = w_data; got_w_strb = w_strb; end
        else w_cnt++;
      end
      if (b_valid) b_valid = 0;
      else if (b_ready) begin
        if (b_cnt >= b_lat) begin b_valid = 1; b_resp = wr_resp; b_cnt = 0; end
        else b_cnt++;
      end
    end
  end

  // Monitor: completion pulses are popped against the scoreboard; bus stability is watched every cycle.
  always @(negedge aclk) begin
    if (reset) begin
      pv_ar = 0; pv_aw = 0; pv_w = 0;
    end else begin
      n_checks++;
      if ((mem_done != MD_NONE) !== rv_m_ready) begin
        n_fail++; $display("FAIL done_pulse: mem_done=%b ready=%b at cyc %0d", mem_done, rv_m_ready, cyc);
      end
      if (ar_valid && pv_ar) begin
        n_checks++;
        if (ar_addr !== p_ar) begin n_fail++; $display("FAIL ar_stable: got %h want %h", ar_addr, p_ar); end
      end
      if (aw_valid && pv_aw) begin
        n_checks++;
        if (aw_addr !== p_aw) begin n_fail++; $display("FAIL aw_stable: got %h want %h", aw_addr, p_aw); end
      end
      if (w_valid && pv_w) begin
        n_checks++;
        if ({w_data, w_strb} !== p_w) begin n_fail++; $display("FAIL w_stable: got %h want %h", {w_data, w_strb}, p_w); end
      end
      pv_ar = ar_valid; p_ar = ar_addr; pv_aw = aw_valid; p_aw = aw_addr; pv_w = w_valid; p_w = {w_data, w_strb};
      if (rv_m_ready) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL unexpected_ready: got ready at cyc %0d, want none", cyc);
        end else begin
          mon_e = sbq.pop_front();
          n_checks++;
          if (rv_m_rdata !== mon_e.rdata) begin n_fail++; $display("FAIL rdata: got %h want %h", rv_m_rdata, mon_e.rdata); end
          n_checks++;
          if (rv_m_err !== mon_e.err) begin n_fail++; $display("FAIL err: got %b want %b", rv_m_err, mon_e.err); end
          n_checks++;
          if (mem_done !== mon_e.md) begin n_fail++; $display("FAIL mem_done: got %b want %b", mem_done, mon_e.md); end
          n_checks++;
          if (cyc !== mon_e.cyc) begin n_fail++; $display("FAIL latency: ready at cyc %0d want %0d", cyc, mon_e.cyc); end
          n_checks++;
          if ({ar_valid, r_ready, aw_valid, w_valid, b_ready} !== 5'b0) begin
            n_fail++; $display("FAIL bus_idle_at_done: got %b want 00000", {ar_valid, r_ready, aw_valid, w_valid, b_ready});
          end
        end
      end
    end
  end

  // Called at a negedge with the bridge idle; lat is the cycle (after sampling) of the expected ready pulse.
  task automatic issue(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int lat, input logic [DW-1:0] erd,
                       input logic eerr, input logic [1:0] emd);
    exp_t e;
    logic [2:0] want;
    rv_m_valid = 1; rv_m_rw = rw; rv_m_addr = addr; rv_m_wrdata = data; rv_m_wstrb = strb;
    e.rdata = erd; e.err = eerr; e.md = emd; e.cyc = cyc + lat;
    sbq.push_back(e);
    @(negedge aclk);
    rv_m_valid = 0; rv_m_rw = ~rw; rv_m_addr = ~addr; rv_m_wrdata = ~data; rv_m_wstrb = ~strb;
    want = rw ? ((|strb) ? 3'b011 : 3'b000) : 3'b100;
    n_checks++;
    if ({ar_valid, aw_valid, w_valid} !== want) begin
      n_fail++; $display("FAIL first_cycle_valid: got %b want %b", {ar_valid, aw_valid, w_valid}, want);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() != 0 && n < 60) begin @(negedge aclk); n++; end
    if (sbq.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL completion_timeout: %0d transactions pending, want 0", sbq.size());
      sbq.delete();
    end
    @(negedge aclk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    n_checks++;
    if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, rv_m_ready} !== 6'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 000000", {ar_valid, r_ready, aw_valid, w_valid, b_ready, rv_m_ready});
    end
    n_checks++;
    if (rv_m_rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rv_m_rdata); end
    n_checks++;
    if (rv_m_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rv_m_err); end
    n_checks++;
    if (mem_done !== MD_NONE) begin n_fail++; $display("FAIL reset_mem_done: got %b want 00", mem_done); end
    n_checks++;
    if ({ar_prot, aw_prot} !== 6'b0) begin n_fail++; $display("FAIL prot: got %b want 000000", {ar_prot, aw_prot}); end
    reset = 0;
    @(negedge aclk);
  endtask

  task automatic test_read_basic();
    rd_val = 32'hDEADBEEF; rd_resp = OKAY;
    issue(0, 32'h100, '0, '0, 3, 32'hDEADBEEF, 0, MD_RD);
    wait_done();
    n_checks++;
    if (got_ar_addr !== 32'h100) begin n_fail++; $display("FAIL ar_addr: got %h want 00000100", got_ar_addr); end
  endtask

  task automatic test_zero_strb();
    int aw0 = aw_seen, w0 = w_seen;
    issue(1, 32'h300, 32'hA5A5A5A5, 4'b0000, 1, '0, 0, MD_WR);
    wait_done();
    n_checks++;
    if (aw_seen !== aw0 || w_seen !== w0) begin
      n_fail++; $display("FAIL zero_strb_traffic: aw/w valid cycles %0d/%0d want 0/0", aw_seen - aw0, w_seen - w0);
    end
  endtask

  task automatic test_write_strb();
    aw_lat = 2; w_lat = 0; b_lat = 0; wr_resp = OKAY;
    issue(1, 32'h200, 32'h12345678, 4'b0011, 5, '0, 0, MD_WR);
    wait_done();
    aw_lat = 0;
    n_checks++;
    if (got_w_strb !== 4'b0011) begin n_fail++; $display("FAIL w_strb: got %b want 0011", got_w_strb); end
    n_checks++;
    if (got_w_data !== 32'h12345678) begin n_fail++; $display("FAIL w_data: got %h want 12345678", got_w_data); end
    n_checks++;
    if (got_aw_addr !== 32'h200) begin n_fail++; $display("FAIL aw_addr: got %h want 00000200", got_aw_addr); end
  endtask

  task automatic test_errors();
    rd_val = 32'hBAD0BAD0; rd_resp = SLVERR;
    issue(0, 32'h104, '0, '0, 3, 32'hBAD0BAD0, 1, MD_RD);
    wait_done();
    rd_val = 32'h0000C0DE; rd_resp = OKAY;
    issue(0, 32'h108, '0, '0, 3, 32'h0000C0DE, 0, MD_RD);
    wait_done();
    wr_resp = DECERR;
    issue(1, 32'h10C, 32'h11112222, 4'b1111, 3, '0, 1, MD_WR);
    wait_done();
    wr_resp = OKAY;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      logic rw = 1'($urandom_range(0, 1));
      logic [SW-1:0] strb = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom_range(1, 15));
      logic [DW-1:0] d = $urandom;
      logic [1:0] resp = 2'($urandom_range(0, 3));
      ar_lat = $urandom_range(0, 2); r_lat = $urandom_range(0, 2);
      aw_lat = $urandom_range(0, 2); w_lat = $urandom_range(0, 2); b_lat = $urandom_range(0, 2);
      rd_val = d; rd_resp = resp; wr_resp = resp;
      if (!rw) issue(0, $urandom, '0, '0, 3 + ar_lat + r_lat, d, resp[1], MD_RD);
      else if (strb == '0) issue(1, $urandom, d, strb, 1, '0, 0, MD_WR);
      else issue(1, $urandom, d, strb, 3 + ((aw_lat > w_lat) ? aw_lat : w_lat) + b_lat, '0, resp[1], MD_WR);
      wait_done();
    end
    ar_lat = 0; r_lat = 0; aw_lat = 0; w_lat = 0; b_lat = 0; rd_resp = OKAY; wr_resp = OKAY;
  endtask

  task automatic test_timeout();
    rd_val = 32'hFFFF0000; rd_resp = OKAY;
    issue(0, 32'h400, 32'h0, '0, 3, 32'hFFFF0000, 0, MD_RD);
    wait_done();
    ar_never = 1;
    issue(0, 32'h404, '0, '0, 9, '0, 1, MD_TO);
    wait_done();
    ar_never = 0;
  endtask

  task automatic test_reset_mid();
    rd_val = 32'hCAFEF00D; rd_resp = SLVERR;
    issue(0, 32'h500, '0, '0, 3, 32'hCAFEF00D, 1, MD_RD);
    wait_done();
    rd_resp = OKAY; b_lat = 20;
    issue(1, 32'h504, 32'h55AA55AA, 4'b1111, 0, '0, 0, MD_WR);
    void'(sbq.pop_back());
    @(negedge aclk);
    n_checks++;
    if (b_ready !== 1'b1) begin n_fail++; $display("FAIL wr_resp_reached: b_ready got %b want 1", b_ready); end
    #2 reset = 1;
    #1;
    n_checks++;
    if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, rv_m_ready} !== 6'b0) begin
      n_fail++; $display("FAIL async_reset_handshakes: got %b want 000000", {ar_valid, r_ready, aw_valid, w_valid, b_ready, rv_m_ready});
    end
    n_checks++;
    if ({rv_m_rdata, rv_m_err, mem_done} !== '0) begin
      n_fail++; $display("FAIL async_reset_outputs: rdata %h err %b md %b want 0", rv_m_rdata, rv_m_err, mem_done);
    end
    repeat (2) @(negedge aclk);
    reset = 0; b_lat = 0;
    @(negedge aclk);
    rd_val = 32'h13579BDF;
    issue(0, 32'h508, '0, '0, 3, 32'h13579BDF, 0, MD_RD);
    wait_done();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_zero_strb();
    test_write_strb();
    test_errors();
    test_back_to_back();
`ifdef NTA_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
endmodule

// File: doc/rv_axil_bridge.md
# rv_axil_bridge

Parametrised bridge from the RISC-V native memory port to an AXI4-Lite master. It generalises the native-to-AXI bridge with configurable address/data width, per-byte write strobes, registered AXI outputs, response-error reporting and an optional watchdog timeout. It sits between the core's data port and the AXI4-Lite interconnect and handles one transaction at a time.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides
- DATA_W, 32, data width; 32 or 64 only; STRB_W = DATA_W/8
- TIMEOUT_CYCLES, 255, watchdog limit; used only with NTA_TIMEOUT_EN; range 1..65535

Ports:
- aclk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- rv_m_valid  in  1  request valid; held until rv_m_ready
- rv_m_rw  in  1  0 read, 1 write
- rv_m_addr  in  ADDR_W  address
- rv_m_wrdata  in  DATA_W  write data
- rv_m_wstrb  in  STRB_W  write byte enables
- rv_m_ready  out  1  one-cycle completion pulse
- rv_m_rdata  out  DATA_W  read data, valid with rv_m_ready
- rv_m_err  out  1  error flag, valid with rv_m_ready
- mem_done  out  2  01 read done, 10 write done, 11 timeout, else 00
- ar_addr / ar_prot / ar_valid / ar_ready  out/out/in…: ADDR_W / 3 / 1 / 1; ar_prot fixed 000
- r_data / r_resp / r_valid / r_ready: in DATA_W / in 2 / in 1 / out 1
- aw_addr / aw_prot / aw_valid / aw_ready: out ADDR_W / out 3 / out 1 / in 1; aw_prot fixed 000
- w_data / w_strb / w_valid / w_ready: out DATA_W / out STRB_W / out 1 / in 1
- b_resp / b_valid / b_ready: in 2 / in 1 / out 1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE: when rv_m_valid=1, latch rw, addr, wrdata, wstrb. A read goes to RD_ADDR. A write with wstrb≠0 goes to WR. A write with wstrb=0 goes straight to DONE with err=0 and issues no AXI traffic.
- RD_ADDR: ar_valid=1 until ar_valid&ar_ready, then RD_DATA.
- RD_DATA: r_ready=1. On r_valid, capture r_data into rdata and set err=r_resp[1], then DONE.
- WR: aw_valid and w_valid are raised together and dropped independently on their own handshakes, each tracked by a done flag. When both flags are set, go to WR_RESP. Handshakes may complete in the same or in different cycles.
- WR_RESP: b_ready=1. On b_valid, set err=b_resp[1], then DONE.
- DONE: rv_m_ready=1 and mem_done set for exactly one cycle, then IDLE.
- rv_m_rdata holds the last captured value and is zero after a write.
- Once a request is latched, deasserting rv_m_valid has no effect; the AXI transaction still completes and the DONE pulse is still issued.
- AXI address and data outputs are stable while their valid is high.
- Reset: every valid and ready output is 0, rv_m_rdata=0, rv_m_err=0, mem_done=00, state IDLE.

## Timing
- All outputs are registered.
- Request sampled at edge 0. ar_valid or aw_valid/w_valid goes high in cycle 1.
- Minimum read latency is 3 cycles (ar_ready in cycle 1, r_valid in cycle 2, rv_m_ready in cycle 3).
- Minimum write latency is 3 cycles. A write with zero strobes completes in 1 cycle.
- A new request is accepted no earlier than the cycle after DONE.
- Reset asserted mid-transaction drops all AXI valids and readys immediately, with no completion pulse. The downstream slave must be reset together with the bridge.

## Configuration
- NTA_TIMEOUT_EN defined:
  - A 16-bit counter clears on leaving IDLE and increments in every non-IDLE, non-DONE cycle.
  - When it reaches TIMEOUT_CYCLES, all AXI valids and readys drop, and the bridge goes to DONE with rv_m_err=1, rv_m_rdata=0, mem_done=11.
- NTA_TIMEOUT_EN undefined: no counter; the bridge waits indefinitely and mem_done is never 11.

## Structure
- Package nta_pkg holds:
  - the state enum
  - AXI resp constants OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11
  - mem_done codes MD_NONE, MD_RD, MD_WR, MD_TO
- One sub-module, nta_watchdog: counter plus expiry compare, instantiated only under NTA_TIMEOUT_EN.

## Test plan
- Read at 0x100 with zero-wait slave returning 0xDEADBEEF, OKAY: ar_valid in cycle 1; rv_m_ready, rdata=0xDEADBEEF, err=0, mem_done=01 in cycle 3.
- Write 0x12345678 with strb 0011: aw_ready 2 cycles late, w_ready immediate, b OKAY: w_strb=0011 on the bus; single ready pulse with mem_done=10 only after b handshake.
- Write with strb 0000: rv_m_ready in cycle 1, no aw/w valid ever asserted.
- Read returning SLVERR (10): rv_m_err=1 with ready pulse; next read returning OKAY gives err=0.
- NTA_TIMEOUT_EN with TIMEOUT_CYCLES=8, slave never asserts ar_ready: ar_valid drops and rv_m_ready=1, err=1, mem_done=11 after 8 waiting cycles.
- Reset asserted while in WR_RESP: all outputs zero asynchronously; a subsequent read completes normally.
